// File: rtl/serial_word_collector_pkg.sv
// Shared constants and state encoding for the 8-slot serial switch link.
package serial_word_collector_pkg;
  localparam int LINK_WIDTH = 8;
  localparam int LINK_SEL_W = $clog2(LINK_WIDTH);

  typedef enum logic {HUNT, COLLECT} state_t;
endpackage

// File: rtl/frame_stability_counter.sv
// Counts consecutive identical complete frames; word_stable is registered alongside word.
module frame_stability_counter #(
  parameter int STABLE_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_done,
  input  logic       same,
  input  logic       err,
  output logic [3:0] count,
  output logic       stable
);
  logic [3:0] count_nxt;

  always_comb begin
    count_nxt = count;
    if (err)
      count_nxt = '0;
    else if (frame_done)
      count_nxt = !same ? 4'd1 :
                  (count >= 4'(STABLE_FRAMES)) ? count : count + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      stable <= 1'b0;
    end else begin
      count  <= count_nxt;
      stable <= (count_nxt >= 4'(STABLE_FRAMES));
    end
  end
endmodule

// File: rtl/serial_word_collector.sv
// Reassembles one WIDTH-bit word per frame from the slot-multiplexed serial bit and
// flags slot-sequence violations.
module serial_word_collector
  import serial_word_collector_pkg::*;
#(
  parameter int WIDTH         = LINK_WIDTH,
  parameter int SEL_W         = LINK_SEL_W,
  parameter int STABLE_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sdata,
  input  logic [SEL_W-1:0] slot,
  input  logic             slot_en,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  output logic             word_stable,
  output logic             frame_err
);
  state_t           state;
  logic [SEL_W-1:0] expected;
  logic [WIDTH-1:0] asm_q;
  logic [WIDTH-1:0] full_word;
  logic             frame_done;
  logic             seq_err;
  logic [3:0]       stable_count;

  // Completed word includes the bit being sampled on the closing edge.
  always_comb begin
    full_word            = asm_q;
    full_word[WIDTH-1]   = sdata;
  end

  assign frame_done = slot_en && (state == COLLECT) && (slot == expected) &&
                      (slot == SEL_W'(WIDTH-1));
  assign seq_err    = slot_en && (state == COLLECT) && (slot != expected);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      expected   <= '0;
      asm_q      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (slot_en) begin
        case (state)
          HUNT: begin
            if (slot == '0) begin
              asm_q    <= {{(WIDTH-1){1'b0}}, sdata};
              expected <= SEL_W'(1);
              state    <= COLLECT;
            end
          end
          COLLECT: begin
            if (slot == expected) begin
              asm_q[slot] <= sdata;
              if (frame_done) begin
                word       <= full_word;
                word_valid <= 1'b1;
                expected   <= '0;
                state      <= HUNT;
              end else begin
                expected <= expected + 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              // A stray slot 0 is taken as the start of a fresh frame.
              if (slot == '0) begin
                asm_q    <= {{(WIDTH-1){1'b0}}, sdata};
                expected <= SEL_W'(1);
              end else begin
                asm_q    <= '0;
                expected <= '0;
                state    <= HUNT;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  frame_stability_counter #(.STABLE_FRAMES(STABLE_FRAMES)) u_stab (
    .clk        (clk),
    .rst        (rst),
    .frame_done (frame_done),
    .same       (full_word == word),
    .err        (seq_err),
    .count      (stable_count),
    .stable     (word_stable)
  );

  count_bounded: assert property (@(posedge clk) disable iff (rst)
    stable_count <= 4'(STABLE_FRAMES));
endmodule

// File: tb/tb_serial_word_collector.sv
// Table-driven directed checks plus randomized frames against a queue-based reference.
module tb_serial_word_collector;
  localparam int W  = 8;
  localparam int SF = 2;

  logic         clk, rst, sdata, slot_en;
  logic [2:0]   slot;
  logic [W-1:0] word;
  logic         word_valid, word_stable, frame_err;

  int passed = 0;
  int total  = 0;

  serial_word_collector #(.WIDTH(W), .SEL_W(3), .STABLE_FRAMES(SF)) dut (
    .clk(clk), .rst(rst), .sdata(sdata), .slot(slot), .slot_en(slot_en),
    .word(word), .word_valid(word_valid), .word_stable(word_stable), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         en;
    logic [2:0]   slot;
    logic         d;
    logic [W-1:0] w;
    logic         v, s, e;
  } vec_t;
  vec_t tbl[$];

  // Reference: bits of the frame in progress, and the complete frames seen since the
  // last reset or sequence error.
  int           coll[$];
  logic [W-1:0] hist[$];
  logic [W-1:0] m_word;
  logic         m_valid, m_stable, m_err;

  task automatic add(input logic en, input int s, input logic d, input logic [W-1:0] w,
                     input logic v, input logic st, input logic e);
    vec_t x;
    x.en = en; x.slot = 3'(s); x.d = d; x.w = w; x.v = v; x.s = st; x.e = e;
    tbl.push_back(x);
  endtask

  task automatic chk(input string name, input logic [W+2:0] act, input logic [W+2:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got word=%h v=%b s=%b e=%b, want word=%h v=%b s=%b e=%b",
                  name, act[W+2:3], act[2], act[1], act[0], exp[W+2:3], exp[2], exp[1], exp[0]);
  endtask

  function automatic int run_len();
    int n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != hist[hist.size()-1]) break;
      n++;
    end
    return n;
  endfunction

  task automatic model_reset();
    coll.delete(); hist.delete();
    m_word = '0; m_valid = 0; m_stable = 0; m_err = 0;
  endtask

  task automatic model(input logic en, input int s, input logic d);
    logic [W-1:0] w;
    m_valid = 0; m_err = 0;
    if (!en) return;
    if (coll.size() == 0) begin
      if (s == 0) coll.push_back(int'(d));
    end else if (s == coll.size()) begin
      coll.push_back(int'(d));
      if (coll.size() == W) begin
        w = '0;
        for (int i = 0; i < W; i++) w[i] = coll[i][0];
        hist.push_back(w);
        m_word = w; m_valid = 1;
        coll.delete();
      end
    end else begin
      m_err = 1;
      hist.delete(); coll.delete();
      if (s == 0) coll.push_back(int'(d));
    end
    m_stable = (run_len() >= SF);
  endtask

  task automatic drive(input logic en, input int s, input logic d);
    @(negedge clk);
    slot_en = en; slot = 3'(s); sdata = d;
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] pa, pb, pat;
  logic [W-1:0] pats [3];
  int           s_r;
  logic         en_r;

  initial begin
    rst = 1'b1; slot_en = 0; slot = '0; sdata = 0;
    model_reset();
    #1;
    chk("reset_state", {word, word_valid, word_stable, frame_err}, '0);
    @(negedge clk); rst = 1'b0;

    pa = 8'b0110_0101; pb = 8'h3C;
    // first frame, repeat, different frame
    for (int i = 0; i < 7; i++) add(1, i, pa[i], '0, 0, 0, 0);
    add(1, 7, pa[7], pa, 1, 0, 0);
    for (int i = 0; i < 7; i++) add(1, i, pa[i], pa, 0, 0, 0);
    add(1, 7, pa[7], pa, 1, 1, 0);
    for (int i = 0; i < 7; i++) add(1, i, pb[i], pa, 0, 1, 0);
    add(1, 7, pb[7], pb, 1, 0, 0);
    // 0,1,2,5 then a stray slot while hunting
    for (int i = 0; i < 3; i++) add(1, i, 1, pb, 0, 0, 0);
    add(1, 5, 0, pb, 0, 0, 1);
    add(1, 1, 0, pb, 0, 0, 0);
    // 0,1,2,0,1..7 restart
    for (int i = 0; i < 3; i++) add(1, i, pb[i], pb, 0, 0, 0);
    add(1, 0, pb[0], pb, 0, 0, 1);
    for (int i = 1; i < 7; i++) add(1, i, pb[i], pb, 0, 0, 0);
    add(1, 7, pb[7], pb, 1, 0, 0);
    // hunting through slots 3..7, then a clean frame
    for (int i = 3; i < 8; i++) add(1, i, 1, pb, 0, 0, 0);
    for (int i = 0; i < 7; i++) add(1, i, pb[i], pb, 0, 0, 0);
    add(1, 7, pb[7], pb, 1, 1, 0);
    // error while stable clears word_stable
    add(1, 0, 1, pb, 0, 1, 0);
    add(1, 3, 1, pb, 0, 0, 1);
    // slot_en toggling mid-frame
    for (int i = 0; i < 7; i++) begin
      add(1, i, pa[i], pb, 0, 0, 0);
      add(0, 7 - i, ~pa[i], pb, 0, 0, 0);
    end
    add(1, 7, pa[7], pa, 1, 0, 0);
    add(0, 0, 1, pa, 0, 0, 0);

    foreach (tbl[k]) begin
      drive(tbl[k].en, int'(tbl[k].slot), tbl[k].d);
      model(tbl[k].en, int'(tbl[k].slot), tbl[k].d);
      chk($sformatf("vec%0d", k), {word, word_valid, word_stable, frame_err},
          {tbl[k].w, tbl[k].v, tbl[k].s, tbl[k].e});
    end

    // asynchronous reset mid-frame
    for (int i = 0; i < 5; i++) drive(1, i, pb[i]);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async_reset", {word, word_valid, word_stable, frame_err}, '0);
    @(negedge clk); slot_en = 0; rst = 1'b0;
    for (int i = 5; i < 8; i++) begin
      drive(1, i, pb[i]);
      model(1, i, pb[i]);
      chk($sformatf("post_reset_slot%0d", i), {word, word_valid, word_stable, frame_err},
          {m_word, m_valid, m_stable, m_err});
    end

    // randomized frames from a small pattern pool so repeats occur
    pats[0] = 8'h5A; pats[1] = 8'hA5; pats[2] = 8'h00;
    pat = pats[0];
    for (int n = 0; n < 3000; n++) begin
      en_r = ($urandom_range(0, 5) != 0);
      if (coll.size() == 0) s_r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 0;
      else s_r = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 7)) : coll.size();
      if (en_r && s_r == 0) pat = pats[$urandom_range(0, 2)];
      drive(en_r, s_r, pat[s_r]);
      model(en_r, s_r, pat[s_r]);
      chk($sformatf("rand%0d", n), {word, word_valid, word_stable, frame_err},
          {m_word, m_valid, m_stable, m_err});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/serial_word_collector.md
# serial_word_collector

Receive-side stage for the 8-slot time-multiplexed serial link that carries the switch bank one bit per slot. Consumes the serial bit (`sdata`) together with the shared 3-bit slot index. Reassembles complete 8-bit words, checks slot sequencing, and reports when the received word has been stable for a configurable number of frames. Its outputs drive LED/display logic with a clean, framed copy of the switch byte instead of the raw per-slot stream.

## Interface
- `WIDTH`, 8: word width; equals the number of slots per frame.
- `SEL_W`, 3: slot index width, log2(`WIDTH`).
- `STABLE_FRAMES`, 2: number of consecutive identical complete frames required before `word_stable` asserts; legal range 1..15.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sdata`  in  1  serial bit belonging to slot `slot`.
- `slot`  in  `SEL_W`  index of the bit currently on `sdata`.
- `slot_en`  in  1  qualifies `sdata`/`slot`; the block ignores both when low.
- `word`  out  `WIDTH`  last complete frame; bit i = `sdata` sampled in slot i.
- `word_valid`  out  1  single-cycle pulse when `word` is updated.
- `word_stable`  out  1  high while the last `STABLE_FRAMES` frames were identical.
- `frame_err`  out  1  single-cycle pulse on a slot-sequence violation.

## Operation
- The FSM has two states:
  - HUNT: waits for the start of a frame.
  - COLLECT: accumulates slots 0..`WIDTH`-1 in order.
- Reset: state HUNT. All outputs, the shift/assembly register, the expected-slot counter and the stable counter are 0.
- HUNT:
  - `slot_en` with `slot`==0: store `sdata` in assembly bit 0, set expected=1, go to COLLECT.
  - Any other slot: ignored, with no error.
- COLLECT, `slot_en` with `slot`==expected:
  - Store `sdata` in assembly bit `slot` and increment expected.
  - If `slot`==`WIDTH`-1, the frame is complete:
    - Load `word` with the assembled value, including the bit just sampled.
    - Pulse `word_valid`.
    - Go to HUNT with expected=0.
- COLLECT, `slot_en` with `slot`!=expected:
  - Pulse `frame_err` and discard the partial assembly.
  - If `slot`==0, restart the frame in the same cycle: capture bit 0, expected=1, stay in COLLECT.
  - Otherwise go to HUNT.
- COLLECT, `slot_en` low: hold all state. There is no timeout.
- Stable counter (4 bits, saturates at `STABLE_FRAMES`):
  - On a complete frame equal to the current `word`: increment, saturating.
  - On a complete frame that differs: set to 1.
  - The first frame after reset counts as a difference, because `word` is 0 with count 0; it sets count to 1 even if the frame value is 0.
  - On `frame_err`: clear to 0.
- `word_stable` = (count >= `STABLE_FRAMES`). It is registered and updates on the same edge as `word`.
- `word` is never cleared by `frame_err`; it holds the last good frame.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Frame completion:
  - The edge that samples slot `WIDTH`-1 updates `word`, `word_valid` and `word_stable`.
  - The new values are visible for the cycle after that edge.
  - `word_valid` is high for exactly that one cycle.
- Frame error: `frame_err` is high for the one cycle following the offending edge.
- Throughput: back-to-back frames are supported. The slot-0 sample on the cycle after a completion starts the next frame without a gap.
- Reset asserted mid-frame: all state and outputs drop to reset values immediately, without waiting for a clock edge. The first complete frame after release must start at slot 0.
- Simultaneous events: `word_valid` and `frame_err` are mutually exclusive by construction.

## Structure
- Shared package holds:
  - the `WIDTH` and `SEL_W` constants used by the slot counter, mux, demux and this block;
  - the two-value state enum (`HUNT`, `COLLECT`).
- One sub-module is natural: `frame_stability_counter`.
  - Inputs: the frame-complete strobe, a new==old compare result, and the error strobe.
  - Outputs: the saturating count and `word_stable`.
- Top level keeps the FSM, expected-slot counter and assembly register.

## Test plan
- Reset, then slots 0..7 in order with `sdata`=1,0,1,0,0,1,1,0, `slot_en` high throughout:
  - `word`=8'b0110_0101, with one `word_valid` pulse;
  - `word_stable`=0 with `STABLE_FRAMES`=2.
- Same frame sent twice back-to-back:
  - second `word_valid` pulse;
  - `word_stable` rises with it;
  - a third, different frame drops `word_stable` on its `word_valid` cycle.
- Slot sequence 0,1,2,5:
  - `frame_err` pulses once;
  - `word` is unchanged;
  - FSM returns to HUNT and the stable count is 0.
- Slot sequence 0,1,2,0,1..7 (restart):
  - `frame_err` pulses once at the second slot 0;
  - the following complete frame loads `word` and pulses `word_valid`.
- Start in HUNT with slots 3..7, then a full 0..7 frame: no `frame_err`, exactly one `word_valid`.
- `slot_en` toggling 1/0 every cycle during a frame: identical result to the contiguous frame.
- Assert `rst` after slot 4, then release:
  - all outputs are 0 immediately;
  - the remaining slots 5..7 produce nothing.
